// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: one shift-add or restoring
// shift-subtract step per cycle. Optional macro MDU_FAST_ZERO_EN short-cuts zero-operand multiplies.
module mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [1:0]      dbg_state
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;

    // Operand conditioning on accept
    logic            is_div, a_signed, b_signed, a_neg, b_neg, neg_sel;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            special;
    logic [XLEN-1:0] special_val;

    always_comb begin
        is_div   = funct3[2];
        a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
        b_signed = a_signed && (funct3 != 3'b010);
        a_neg    = a_signed && srca[XLEN-1];
        b_neg    = b_signed && srcb[XLEN-1];
        mag_a    = a_neg ? -srca : srca;
        mag_b    = b_neg ? -srcb : srcb;
        // Remainder follows the dividend sign; everything else is the XOR
        neg_sel  = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
    end

    always_comb begin
        special     = 1'b0;
        special_val = '0;
        if (is_div && (srcb == '0)) begin
            special     = 1'b1;
            special_val = funct3[1] ? srca : '1;
        end else if (is_div && !funct3[0] && (srca == MIN_NEG) && (srcb == '1)) begin
            special     = 1'b1;
            special_val = funct3[1] ? '0 : srca;
        end
`ifdef MDU_FAST_ZERO_EN
        else if (!is_div && ((srca == '0) || (srcb == '0))) begin
            special     = 1'b1;
            special_val = '0;
        end
`else
`endif
    end

    // One iteration of the datapath; acc holds {hi, lo}
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] step, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_val;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (!div_diff[XLEN])
                step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else
                step = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            step = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod_fix = neg_q ? -step : step;
        quo_fix  = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
        rem_fix  = neg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        if (op_q[2])
            final_val = op_q[1] ? rem_fix : quo_fix;
        else
            final_val = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            result_q <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = special ? DONE : CALC;
            CALC:    if (count_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        result_d = result_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        if (state_q == IDLE && start) begin
            op_d    = funct3;
            neg_d   = neg_sel;
            count_d = '0;
            if (special) begin
                result_d = special_val;
            end else begin
                opnd_d = is_div ? mag_b : mag_a;
                acc_d  = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            end
        end else if (state_q == CALC) begin
            acc_d   = step;
            count_d = count_q + 1'b1;
            if (count_q == LAST) result_d = final_val;
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        stall     = ((state_q == IDLE) && start) || (state_q == CALC);
        result    = result_q;
        dbg_state = state_q;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer for the RV32M extension; runs alongside the single-cycle ALU.
- Accepts one M-type op from the control path, iterates one bit per cycle, and asserts a stall to freeze PC and the register-file write until the result is ready.
- Result is muxed into the writeback path in the cycle `done` is high.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk     input   1     rising-edge clock
- reset   input   1     asynchronous, active-high reset
- start   input   1     M-type instruction in decode; level, held by frozen PC
- funct3  input   3     000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- srca    input   XLEN  rs1 value, sampled on accept
- srcb    input   XLEN  rs2 value, sampled on accept
- stall   output  1     freeze PC/writeback
- busy    output  1     state != IDLE
- done    output  1     one-cycle result-valid pulse
- result  output  XLEN  registered result; valid when done=1

Behaviour:
- Reset (async): state=IDLE, count=0, result=0, done=0, busy=0, stall=0 (start low). Internal acc/quotient/operand registers cleared.
- States and transitions:
  - IDLE -> CALC on start=1: latch funct3 and operand magnitudes, plus the result sign.
  - IDLE -> DONE directly on a special case (below).
  - CALC: one shift-add (mul) or restoring shift-subtract (div) step per cycle; count 0..XLEN-1. At count=XLEN-1: apply sign fix, load result, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: start high in cycle C -> done high in cycle C+XLEN+1 (C+33 for XLEN=32); special cases -> done in C+1.
- Stall: stall = (IDLE & start) | CALC. It is combinational from start in IDLE and is low in DONE, so the instruction retires in the DONE cycle.
- Signedness:
  - mul and mulh: both operands signed.
  - mulhsu: srca signed, srcb unsigned.
  - mulhu, divu, remu: unsigned.
  - div and rem: signed.
  - mul returns low XLEN bits of the 2*XLEN product; mulh* return high XLEN bits.
  - Magnitudes are computed on accept; negation of the 2*XLEN product or of quotient/remainder is applied at the last CALC step.
- Division sign rules: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a); truncation toward zero.
- Special cases (checked in IDLE on accept, no CALC):
  - Divisor 0: div/divu -> all ones; rem/remu -> srca.
  - Signed overflow (div/rem, srca = most-negative value, srcb = -1): div -> srca; rem -> 0.
- start while busy: ignored; operands are not re-sampled.
- start in DONE: ignored; re-evaluated in IDLE next cycle, so back-to-back ops incur one idle cycle.
- result holds its value after DONE until the next load. Reset mid-CALC aborts immediately to IDLE; no done pulse.

Optional Feature:
- Macro: MDU_FAST_ZERO_EN.
- Defined: mul/mulh/mulhsu/mulhu with srca==0 or srcb==0 take the special-case path. result=0, done in C+1, no CALC.
- Not defined: zero operands iterate the full XLEN cycles like any multiply. Final values are identical either way; only latency differs.

Test Plan:
- mul, srca=7, srcb=0xFFFFFFFD -> result 0xFFFFFFEB; done in C+33; stall high C..C+32, low C+33.
- mulhu, srca=srcb=0xFFFFFFFF -> 0xFFFFFFFE. mulh, same operands -> 0x00000000. mulhsu, srca=0xFFFFFFFF, srcb=2 -> 0xFFFFFFFF.
- div, srca=0xFFFFFFF9 (-7), srcb=2 -> 0xFFFFFFFD. rem, same operands -> 0xFFFFFFFF. remu, srca=100, srcb=7 -> 2.
- Divisor zero: divu 5/0 -> 0xFFFFFFFF; rem 5/0 -> 5; both with done in C+1. Overflow: div 0x80000000/0xFFFFFFFF -> 0x80000000; rem same operands -> 0; both done in C+1.
- Assert reset at CALC count=10 -> busy, stall, done, result all 0 immediately. Next start with mul 3*4 -> 12 at C+33.
- MDU_FAST_ZERO_EN defined, mul 0*0x1234 -> result 0, done C+1. Undefined -> done C+33.
